// File: rtl/mux_arb_pkg.sv
// Shared constants for the round-robin data arbiter: FSM encoding, requester
// count, select width and a one-hot grant helper.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] one;
        one = {{(NUM_REQ-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/lane_mux4.sv
// 4:1 data lane selector shared by the arbiter datapath.
module lane_mux4 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
        endcase
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin search: first eligible requester at or after ptr,
// ascending and wrapping from the top index back to 0.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest match is written last.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + k[SEL_W-1:0];
            if (eligible[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that registers the winning lane's data and holds it
// with a valid/ready handshake; one transfer per cycle under full load.
module mux_rr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    input  logic [WIDTH-1:0]   d,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         sel,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] ack
);

    import mux_arb_pkg::*;

    logic [0:0]         state;
    logic [SEL_W-1:0]   ptr;
    logic [NUM_REQ-1:0] eligible;
    logic [SEL_W-1:0]   search_ptr;
    logic               pick_any;
    logic [SEL_W-1:0]   pick_idx;
    logic [WIDTH-1:0]   lane_data;
    logic               busy;
    logic               handshake;

    assign busy      = (state == ST_BUSY);
    assign out_valid = busy;
    assign handshake = busy && out_ready;
    assign ack       = gnt & {NUM_REQ{handshake}};

    // While busy the current winner is masked and the search begins just past
    // it, which is exactly where ptr lands if this cycle completes a transfer.
    assign eligible   = busy ? (req & ~gnt) : req;
    assign search_ptr = busy ? (sel + 2'd1) : ptr;

    rr_pick u_pick (
        .eligible (eligible),
        .ptr      (search_ptr),
        .any      (pick_any),
        .idx      (pick_idx)
    );

    lane_mux4 #(.WIDTH(WIDTH)) u_lane_mux (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .sel (pick_idx),
        .y   (lane_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            out   <= '0;
            sel   <= '0;
            gnt   <= '0;
            ptr   <= '0;
        end else if (!busy) begin
            if (pick_any) begin
                state <= ST_BUSY;
                out   <= lane_data;
                sel   <= pick_idx;
                gnt   <= onehot(pick_idx);
            end
        end else if (out_ready) begin
            // Transfer accepted: rotate priority and chain straight into the
            // next winner if anyone else is waiting.
            ptr <= sel + 2'd1;
            if (pick_any) begin
                out <= lane_data;
                sel <= pick_idx;
                gnt <= onehot(pick_idx);
            end else begin
                state <= ST_IDLE;
                gnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: table of single-grant transfers from idle
// plus hand-written reset, fairness, backpressure, drop and wrap sequences.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] a, b, c, d;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic [3:0] ack;

    int compared = 0;
    int mismatched = 0;

    mux_rr_arbiter #(.WIDTH(8), .NUM_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .gnt       (gnt),
        .ack       (ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [7:0] a, b, c, d;
        logic [1:0] exp_sel;
        logic [7:0] exp_out;
        logic [3:0] exp_gnt;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Hand-computed: ptr starts at 0 and becomes winner+1 after each accepted transfer.
        vecs[0] = '{4'b0100, 8'hA1, 8'hB1, 8'h3C, 8'hD1, 2'd2, 8'h3C, 4'b0100};
        vecs[1] = '{4'b0011, 8'hA2, 8'hB2, 8'hC2, 8'hD2, 2'd0, 8'hA2, 4'b0001};
        vecs[2] = '{4'b1001, 8'hA3, 8'hB3, 8'hC3, 8'hD3, 2'd3, 8'hD3, 4'b1000};
        vecs[3] = '{4'b0110, 8'hA4, 8'hB4, 8'hC4, 8'hD4, 2'd1, 8'hB4, 4'b0010};
        vecs[4] = '{4'b1010, 8'hA5, 8'hB5, 8'hC5, 8'hD5, 2'd3, 8'hD5, 4'b1000};
        vecs[5] = '{4'b1000, 8'hA6, 8'hB6, 8'hC6, 8'hD6, 2'd3, 8'hD6, 4'b1000};
        vecs[6] = '{4'b0001, 8'hA7, 8'hB7, 8'hC7, 8'hD7, 2'd0, 8'hA7, 4'b0001};
        vecs[7] = '{4'b1111, 8'hA8, 8'hB8, 8'hC8, 8'hD8, 2'd1, 8'hB8, 4'b0010};

        rst_n = 1'b0;
        req = 4'b0000;
        a = 8'h00; b = 8'h00; c = 8'h00; d = 8'h00;
        out_ready = 1'b0;
        #12;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_out", 32'(out), 32'd0);
        check("reset_sel", 32'(sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: one grant from idle, accepted immediately, then back to idle.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req = vecs[i].req;
            a = vecs[i].a; b = vecs[i].b; c = vecs[i].c; d = vecs[i].d;
            out_ready = 1'b1;
            tick();
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].exp_sel));
            check($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
            check($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].exp_gnt));
            req = 4'b0000;
            tick();
            check($sformatf("vec%0d_idle_valid", i), 32'(out_valid), 32'd0);
            check($sformatf("vec%0d_idle_gnt", i), 32'(gnt), 32'd0);
            check($sformatf("vec%0d_idle_sel", i), 32'(sel), 32'(vecs[i].exp_sel));
        end

        // Asynchronous reset in the middle of a held transfer.
        @(negedge clk);
        req = 4'b0001; a = 8'h5A; out_ready = 1'b0;
        tick();
        check("rst_pre_out", 32'(out), 32'h5A);
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_gnt", 32'(gnt), 32'd0);
        check("rst_async_ack", 32'(ack), 32'd0);
        check("rst_async_out", 32'(out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fairness from a fresh pointer: a,b,c,d,a with no idle cycles.
        req = 4'b1111; a = 8'h01; b = 8'h02; c = 8'h03; d = 8'h04; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("fair%0d_sel", k), 32'(sel), 32'(k % 4));
            check($sformatf("fair%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("fair%0d_out", k), 32'(out), 32'((k % 4) + 1));
            check($sformatf("fair%0d_ack", k), 32'(ack), 32'(4'b0001 << (k % 4)));
        end
        req = 4'b0000;
        tick();
        check("fair_end_valid", 32'(out_valid), 32'd0);

        // Backpressure: captured b data held while the lane changes.
        @(negedge clk);
        req = 4'b0010; b = 8'h11; out_ready = 1'b0;
        tick();
        b = 8'h22;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_out", k), 32'(out), 32'h11);
            check($sformatf("bp%0d_ack", k), 32'(ack), 32'd0);
            check($sformatf("bp%0d_sel", k), 32'(sel), 32'd1);
            tick();
        end
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        req = 4'b0000;
        #1;
        check("bp_ack", 32'(ack), 32'b0010);
        check("bp_final_out", 32'(out), 32'h11);
        tick();
        check("bp_done_valid", 32'(out_valid), 32'd0);

        // Request dropped after grant: transfer still completes.
        @(negedge clk);
        req = 4'b0100; c = 8'h77; out_ready = 1'b0;
        tick();
        req = 4'b0000; c = 8'h99;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("drop%0d_out", k), 32'(out), 32'h77);
            check($sformatf("drop%0d_valid", k), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("drop_ack", 32'(ack), 32'b0100);
        tick();
        check("drop_done_valid", 32'(out_valid), 32'd0);

        // Pointer now 3: lone continuous d request is masked for one cycle.
        @(negedge clk);
        req = 4'b1000; d = 8'hD5; out_ready = 1'b1;
        tick();
        check("wrap_g1_sel", 32'(sel), 32'd3);
        check("wrap_g1_valid", 32'(out_valid), 32'd1);
        check("wrap_g1_ack", 32'(ack), 32'b1000);
        tick();
        check("wrap_gap_valid", 32'(out_valid), 32'd0);
        check("wrap_gap_gnt", 32'(gnt), 32'd0);
        check("wrap_gap_sel", 32'(sel), 32'd3);
        tick();
        check("wrap_g2_valid", 32'(out_valid), 32'd1);
        check("wrap_g2_sel", 32'(sel), 32'd3);
        check("wrap_g2_out", 32'(out), 32'hD5);
        req = 4'b0000;
        d = 8'hEE;
        tick();

        // Idle with no requests: everything holds, out_ready ignored.
        tick();
        tick();
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_out", 32'(out), 32'hD5);
        check("idle_sel", 32'(sel), 32'd3);
        check("idle_ack", 32'(ack), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, data width of each requester lane and of out.
REQ-002 Parameter: NUM_REQ, 4, number of requesters; fixed at 4, matching sel width 2.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: req  input  4  per-requester request; bit0=a, bit1=b, bit2=c, bit3=d.
REQ-006 Port: a, b, c, d  input  WIDTH each  requester data lanes.
REQ-007 Port: out  output  WIDTH  registered data of the granted requester.
REQ-008 Port: out_valid  output  1  out holds a transfer awaiting acceptance.
REQ-009 Port: out_ready  input  1  downstream accepts out when out_valid && out_ready.
REQ-010 Port: sel  output  2  index of current/last granted requester (0=a .. 3=d).
REQ-011 Port: gnt  output  4  one-hot grant, nonzero only while out_valid=1.
REQ-012 Port: ack  output  4  one-hot, combinational: gnt & {4{out_valid && out_ready}}.

Function
REQ-013 States SHALL be IDLE and BUSY; out_valid=1 exactly when state=BUSY.
REQ-014 Arbitration SHALL be round-robin: search order starts at pointer ptr (2 bits), ascending, wrapping 3->0.
REQ-015 IDLE with any eligible req: winner w latched; out<=lane w; sel<=w; gnt<=1<<w; state->BUSY next edge (latency 1 cycle from req to out_valid).
REQ-016 IDLE with req=0: state, out, sel, ptr hold; out_ready ignored.
REQ-017 BUSY without handshake: out, sel, gnt SHALL remain stable; lane data changes and req deassertion ignored (transfer completes).
REQ-018 BUSY with handshake: ptr<=w+1 mod 4; eligible set=req & ~gnt; if nonempty, new winner latched same edge, state stays BUSY (1 transfer/cycle); else state->IDLE, gnt<=0.
REQ-019 Eligible set in IDLE SHALL be req unmasked.
REQ-020 A requester SHALL receive at most one grant per ptr rotation while others request; max wait 3 transfers.
REQ-021 sel SHALL keep last winner when IDLE.

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE, out=0, out_valid=0, sel=0, gnt=0, ptr=0; ack consequently 0.
REQ-023 Reset mid-transfer SHALL discard the pending transfer without ack; first arbitration after release starts from requester a.

Structure
REQ-024 Package mux_arb_pkg SHALL hold state encoding (IDLE=0, BUSY=1), NUM_REQ=4, SEL_W=2.
REQ-025 Sub-module rr_pick (combinational: eligible[3:0], ptr[1:0] -> any, idx[1:0]) SHALL implement the round-robin search.
REQ-026 Existing 4:1 lane mux SHALL be reused for data selection, driven by the arbitration index.

Verification
REQ-027 Reset: rst_n=0 mid-BUSY with out=0x5A -> out_valid, gnt, ack, out go 0 asynchronously; after release req=4'b1111 grants a (sel=0).
REQ-028 Single request: req=4'b0100, c=0x3C, out_ready=1 -> out=0x3C, out_valid=1, sel=2 one cycle later; ack=4'b0100 that cycle.
REQ-029 Fairness: req=4'b1111 held, out_ready=1 -> sel sequence 0,1,2,3,0 on consecutive cycles, no bubbles.
REQ-030 Backpressure: grant b with b=0x11, out_ready=0 for 5 cycles while b changes to 0x22 -> out stays 0x11, ack=0 until out_ready=1.
REQ-031 Wrap/mask: ptr=3, only d requesting continuously -> d granted, then IDLE one cycle (masked), then d regranted.
REQ-032 Drop: req deasserted after grant, out_ready=0 -> transfer still completes with captured data when out_ready=1.
